gaussian_eq_scoreboard: RTL and testbench
=========================================

# gaussian_eq_scoreboard

Downstream consumer of the two Gaussian output streams, the ILA model's `arg_0` and the HLS design's `arg_0`. It accepts both 8-bit pixel streams independently and buffers each in its own FIFO. It then compares the streams pixel by pixel in arrival order. It reports a sticky mismatch with the first failing index and values, a stall error when one side starves the other, and completion after a programmed pixel count.

## Interface
Parameters:
- `DEPTH`, default 16: per-side FIFO depth. Must be a power of two, at least 2.
- `NUM_PIXELS`, default 307200: number of pixels to compare before done (640x480).
- `CNT_W`, default 19: width of the pixel index and compare counters.
- `TIMEOUT`, default 1024: maximum number of consecutive one-sided-stall cycles.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  single-cycle pulse; arms a new comparison run.
- `ila_TDATA`  in  8  ILA output pixel.
- `ila_TVALID`  in  1  ILA pixel valid.
- `ila_TREADY`  out  1  scoreboard can accept an ILA pixel.
- `hls_TDATA`  in  8  HLS output pixel.
- `hls_TVALID`  in  1  HLS pixel valid.
- `hls_TREADY`  out  1  scoreboard can accept an HLS pixel.
- `busy`  out  1  high while in RUN.
- `done`  out  1  sticky; NUM_PIXELS pixels compared with no mismatch.
- `mismatch`  out  1  sticky; the first compared pair differed.
- `stall_err`  out  1  sticky; a one-sided stall reached the TIMEOUT limit.
- `fail_idx`  out  CNT_W  index of the first mismatching pixel.
- `fail_ila`  out  8  ILA value at `fail_idx`.
- `fail_hls`  out  8  HLS value at `fail_idx`.
- `cmp_cnt`  out  CNT_W  number of pairs compared so far.

## Operation
- The FSM has four states: IDLE, RUN, PASS, FAIL. Reset enters IDLE.
- IDLE:
  - TREADY on both sides is 0.
  - A `start` pulse clears both FIFOs, `cmp_cnt`, the stall counter and all sticky flags, then enters RUN.
- RUN:
  - `ila_TREADY = ~ila_full`; `hls_TREADY = ~hls_full`.
  - A push happens on TVALID & TREADY.
  - When both FIFOs are non-empty, both are popped in the same cycle and the pair is compared.
  - Pair equal: `cmp_cnt` increments. When `cmp_cnt` reaches NUM_PIXELS the FSM goes to PASS.
  - Pair differs: capture `fail_idx = cmp_cnt`, `fail_ila`, and `fail_hls`, set `mismatch`, and go to FAIL.
- Stall counter:
  - It increments in any RUN cycle in which exactly one FIFO is non-empty.
  - It clears in any other cycle.
  - When it reaches TIMEOUT, set `stall_err` and go to FAIL.
- PASS / FAIL:
  - TREADY on both sides is 0.
  - Flags and captured values hold.
  - `start` re-arms the block as from IDLE.
- A `start` pulse during RUN is ignored.
- Counters never wrap. `cmp_cnt` saturates at NUM_PIXELS because the FSM leaves RUN at that point.
- Comparison is an exact 8-bit equality. `TLAST` is not consumed.

## Timing
- Reset values:
  - TREADY = 0, `busy` = 0, `done` = 0, `mismatch` = 0, `stall_err` = 0.
  - `fail_*` = 0, `cmp_cnt` = 0.
  - FIFOs empty.
- TREADY is combinational from the registered full flag and the state; it does not depend on TVALID.
- FIFOs are not fall-through. A word pushed at edge N can be popped no earlier than edge N+1.
- Compare latency: both FIFOs non-empty in cycle N means pop at edge N+1. The comparison result, `cmp_cnt`, the flags and the state change are all registered at that same edge.
- `done`/`mismatch`/`stall_err` assert on the same edge as the FSM transition.
- Full FIFO: no push. A simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.
- If `stall_err` and `mismatch` would set on the same edge, `mismatch` wins. The bench never sees both from one event.
- Asynchronous `rst` mid-run clears everything immediately. Data held in the FIFOs is discarded.

## Structure
- Shared package `gaussian_eq_pkg`:
  - state enum (IDLE/RUN/PASS/FAIL);
  - `PIX_W = 8`;
  - default NUM_PIXELS, CNT_W and TIMEOUT constants.
- Sub-module `eq_stream_fifo`:
  - synchronous FIFO, width 8, depth DEPTH;
  - ports: `clk`, `rst`, `clr`, `push`, `din`, `pop`, `dout`, `full`, `empty`;
  - instantiated twice.
- Top level contains the FSM, the stall counter, the compare counter and the capture registers.

## Test plan
- Identical streams: ramp 0..15 on both sides with NUM_PIXELS=16, TVALID held high on both. Required: `done`=1, `cmp_cnt`=16, `mismatch`=0.
- Single corruption: HLS pixel 5 = 0x2A while ILA = 0x05. Required: `mismatch`=1, `fail_idx`=5, `fail_ila`=0x05, `fail_hls`=0x2A, `cmp_cnt`=5, FSM in FAIL.
- Skewed arrival: ILA sends all 16 pixels first, with DEPTH=16; HLS then sends with 3-cycle gaps.
  - Required: `ila_TREADY` drops at occupancy 16.
  - Required: no stall error with TIMEOUT=64.
  - Required: `done`=1.
- Starvation: ILA sends one pixel and HLS sends nothing, with TIMEOUT=64. Required: `stall_err`=1 exactly 64 cycles after the ILA word becomes visible; `done`=0.
- Reset mid-run: assert `rst` after 7 compares. Required: all outputs return to reset values immediately. A new `start` followed by a clean 16-pixel run then reaches `done`.
- Re-arm: after FAIL, pulse `start` and feed matching data. Required: flags cleared at the start edge, then `done`=1.

Source files
------------

// File: rtl/gaussian_eq_pkg.sv
// Shared constants for the Gaussian ILA/HLS equivalence scoreboard.
package gaussian_eq_pkg;

  localparam int unsigned PIX_W          = 8;
  localparam int unsigned DEF_NUM_PIXELS = 307200;
  localparam int unsigned DEF_CNT_W      = 19;
  localparam int unsigned DEF_TIMEOUT    = 1024;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_PASS = 2'd2;
  localparam state_t ST_FAIL = 2'd3;

endpackage

// File: rtl/eq_stream_fifo.sv
// Synchronous, non-fall-through pixel FIFO with a synchronous clear.
module eq_stream_fifo
  import gaussian_eq_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [PIX_W-1:0] din,
  input  logic             pop,
  output logic [PIX_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign dout   = r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/gaussian_eq_scoreboard.sv
// Compares ILA and HLS pixel streams in order; reports pass, first mismatch or stall.
module gaussian_eq_scoreboard
  import gaussian_eq_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] ila_TDATA,
  input  logic             ila_TVALID,
  output logic             ila_TREADY,
  input  logic [PIX_W-1:0] hls_TDATA,
  input  logic             hls_TVALID,
  output logic             hls_TREADY,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             stall_err,
  output logic [CNT_W-1:0] fail_idx,
  output logic [PIX_W-1:0] fail_ila,
  output logic [PIX_W-1:0] fail_hls,
  output logic [CNT_W-1:0] cmp_cnt
);

  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cmp_cnt;
  logic [STALL_W-1:0] r_stall;
  logic               r_done;
  logic               r_mismatch;
  logic               r_stall_err;
  logic [CNT_W-1:0]   r_fail_idx;
  logic [PIX_W-1:0]   r_fail_ila;
  logic [PIX_W-1:0]   r_fail_hls;

  logic               w_run;
  logic               w_clr;
  logic               w_pop;
  logic               w_one_sided;
  logic               w_ila_full, w_ila_empty, w_hls_full, w_hls_empty;
  logic [PIX_W-1:0]   w_ila_dout, w_hls_dout;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [STALL_W-1:0] w_stall_nxt;

  assign w_run       = (r_state == ST_RUN);
  assign w_clr       = ~w_run & start;
  assign ila_TREADY  = w_run & ~w_ila_full;
  assign hls_TREADY  = w_run & ~w_hls_full;
  assign w_pop       = w_run & ~w_ila_empty & ~w_hls_empty;
  assign w_one_sided = w_run & (w_ila_empty ^ w_hls_empty);
  assign w_cnt_nxt   = r_cmp_cnt + CNT_W'(1);
  assign w_stall_nxt = r_stall + STALL_W'(1);

  eq_stream_fifo #(.DEPTH(DEPTH)) u_ila_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .push  (ila_TVALID & ila_TREADY),
    .din   (ila_TDATA),
    .pop   (w_pop),
    .dout  (w_ila_dout),
    .full  (w_ila_full),
    .empty (w_ila_empty)
  );

  eq_stream_fifo #(.DEPTH(DEPTH)) u_hls_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .push  (hls_TVALID & hls_TREADY),
    .din   (hls_TDATA),
    .pop   (w_pop),
    .dout  (w_hls_dout),
    .full  (w_hls_full),
    .empty (w_hls_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cmp_cnt   <= '0;
      r_stall     <= '0;
      r_done      <= 1'b0;
      r_mismatch  <= 1'b0;
      r_stall_err <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_ila  <= '0;
      r_fail_hls  <= '0;
    end else if (w_run) begin
      r_stall <= w_one_sided ? w_stall_nxt : '0;
      if (w_pop) begin
        if (w_ila_dout == w_hls_dout) begin
          r_cmp_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == CNT_W'(NUM_PIXELS)) begin
            r_done  <= 1'b1;
            r_state <= ST_PASS;
          end
        end else begin
          r_mismatch <= 1'b1;
          r_fail_idx <= r_cmp_cnt;
          r_fail_ila <= w_ila_dout;
          r_fail_hls <= w_hls_dout;
          r_state    <= ST_FAIL;
        end
      end else if (w_one_sided && (w_stall_nxt == STALL_W'(TIMEOUT))) begin
        r_stall_err <= 1'b1;
        r_state     <= ST_FAIL;
      end
    end else begin
      // IDLE, PASS and FAIL all re-arm on start.
      r_stall <= '0;
      if (start) begin
        r_state     <= ST_RUN;
        r_cmp_cnt   <= '0;
        r_done      <= 1'b0;
        r_mismatch  <= 1'b0;
        r_stall_err <= 1'b0;
        r_fail_idx  <= '0;
        r_fail_ila  <= '0;
        r_fail_hls  <= '0;
      end
    end
  end

  assign busy      = w_run;
  assign done      = r_done;
  assign mismatch  = r_mismatch;
  assign stall_err = r_stall_err;
  assign fail_idx  = r_fail_idx;
  assign fail_ila  = r_fail_ila;
  assign fail_hls  = r_fail_hls;
  assign cmp_cnt   = r_cmp_cnt;

endmodule

// File: tb/tb_gaussian_eq_scoreboard.sv
// Randomized bench for gaussian_eq_scoreboard against a queue-based reference model.
module tb_gaussian_eq_scoreboard;

  localparam int DEPTH = 16;
  localparam int NPIX  = 16;
  localparam int TMO   = 64;

  logic       clk, rst, start;
  logic [7:0] ila_TDATA, hls_TDATA;
  logic       ila_TVALID, hls_TVALID, ila_TREADY, hls_TREADY;
  logic       busy, done, mismatch, stall_err;
  logic [7:0] fail_idx, fail_ila, fail_hls, cmp_cnt;

  gaussian_eq_scoreboard #(
    .DEPTH(DEPTH), .NUM_PIXELS(NPIX), .CNT_W(8), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ila_TDATA(ila_TDATA), .ila_TVALID(ila_TVALID), .ila_TREADY(ila_TREADY),
    .hls_TDATA(hls_TDATA), .hls_TVALID(hls_TVALID), .hls_TREADY(hls_TREADY),
    .busy(busy), .done(done), .mismatch(mismatch), .stall_err(stall_err),
    .fail_idx(fail_idx), .fail_ila(fail_ila), .fail_hls(fail_hls), .cmp_cnt(cmp_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two queues and the run outcome.
  typedef enum {MIdle, MRun, MPass, MFail} mstate_e;
  mstate_e    m_st = MIdle;
  logic [7:0] q_i[$];
  logic [7:0] q_h[$];
  int m_cnt = 0, m_stall = 0, m_fidx = 0, m_fi = 0, m_fh = 0;
  bit m_done = 0, m_mis = 0, m_serr = 0;
  int cyc = 0, first_push = -1;
  bit acc_i = 0, acc_h = 0;

  task automatic model_reset();
    q_i.delete(); q_h.delete();
    m_st = MIdle; m_cnt = 0; m_stall = 0; m_fidx = 0; m_fi = 0; m_fh = 0;
    m_done = 0; m_mis = 0; m_serr = 0; acc_i = 0; acc_h = 0;
  endtask

  task automatic model_step();
    bit ne_i, ne_h, pop, push_i, push_h;
    logic [7:0] a, b;
    cyc++;
    if (m_st != MRun) begin
      if (start) begin
        model_reset();
        m_st = MRun;
        first_push = -1;
      end
      return;
    end
    ne_i   = q_i.size() != 0;
    ne_h   = q_h.size() != 0;
    pop    = ne_i && ne_h;
    push_i = ila_TVALID && (q_i.size() < DEPTH);
    push_h = hls_TVALID && (q_h.size() < DEPTH);
    a = 8'h00;
    b = 8'h00;
    if (pop) begin
      a = q_i.pop_front();
      b = q_h.pop_front();
    end
    if (push_i) begin
      if (first_push < 0) first_push = cyc;
      q_i.push_back(ila_TDATA);
      acc_i = 1;
    end
    if (push_h) begin
      q_h.push_back(hls_TDATA);
      acc_h = 1;
    end
    if (pop) begin
      if (a == b) begin
        m_cnt++;
        if (m_cnt == NPIX) begin
          m_done = 1;
          m_st = MPass;
        end
      end else begin
        m_mis = 1; m_fidx = m_cnt; m_fi = a; m_fh = b;
        m_st = MFail;
      end
    end
    if (ne_i != ne_h) begin
      m_stall++;
      if (m_stall == TMO && m_st == MRun) begin
        m_serr = 1;
        m_st = MFail;
      end
    end else begin
      m_stall = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Stream drivers: hold TVALID until accepted, optional gap and random throttle.
  logic [7:0] src_i[$];
  logic [7:0] src_h[$];
  int idx_i = 0, idx_h = 0, cool_i = 0, cool_h = 0, gap_i = 0, gap_h = 0;
  int pct_i = 100, pct_h = 100;
  bit en_i = 0, en_h = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ila_tready", int'(ila_TREADY), int'(m_st == MRun && q_i.size() < DEPTH));
        chk("hls_tready", int'(hls_TREADY), int'(m_st == MRun && q_h.size() < DEPTH));
        chk("busy", int'(busy), int'(m_st == MRun));
        chk("done", int'(done), int'(m_done));
        chk("mismatch", int'(mismatch), int'(m_mis));
        chk("stall_err", int'(stall_err), int'(m_serr));
        chk("cmp_cnt", int'(cmp_cnt), m_cnt);
        chk("fail_idx", int'(fail_idx), m_fidx);
        chk("fail_ila", int'(fail_ila), m_fi);
        chk("fail_hls", int'(fail_hls), m_fh);
      end
      if (acc_i) begin
        idx_i++; acc_i = 0; ila_TVALID = 0; cool_i = gap_i;
      end
      if (!ila_TVALID) begin
        if (cool_i > 0) cool_i--;
        else if (en_i && idx_i < src_i.size() && $urandom_range(0, 99) < pct_i) begin
          ila_TVALID = 1; ila_TDATA = src_i[idx_i];
        end
      end
      if (acc_h) begin
        idx_h++; acc_h = 0; hls_TVALID = 0; cool_h = gap_h;
      end
      if (!hls_TVALID) begin
        if (cool_h > 0) cool_h--;
        else if (en_h && idx_h < src_h.size() && $urandom_range(0, 99) < pct_h) begin
          hls_TVALID = 1; hls_TDATA = src_h[idx_h];
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic setup(input int li, input int lh, input bit ramp, input int pi, input int ph,
                       input int gh, input bit eh);
    logic [7:0] v;
    src_i.delete(); src_h.delete();
    for (int k = 0; k < li || k < lh; k++) begin
      v = ramp ? 8'(k) : 8'($urandom);
      if (k < li) src_i.push_back(v);
      if (k < lh) src_h.push_back(v);
    end
    idx_i = 0; idx_h = 0; acc_i = 0; acc_h = 0; cool_i = 0; cool_h = 0;
    ila_TVALID = 0; hls_TVALID = 0;
    pct_i = pi; pct_h = ph; gap_i = 0; gap_h = gh; en_i = 1; en_h = eh;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_end(input string nm);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk({nm, "_ends"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1; start = 0; ila_TVALID = 0; hls_TVALID = 0; ila_TDATA = 0; hls_TDATA = 0;
    model_reset();
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_tready", int'(ila_TREADY | hls_TREADY), 0);
    chk("rst_flags", int'({done, mismatch, stall_err}), 0);
    rst = 0;
    tick();

    // Identical ramp streams.
    setup(16, 16, 1, 100, 100, 0, 1);
    pulse_start();
    wait_end("ident");
    chk("ident_done", int'(done), 1);
    chk("ident_cnt", int'(cmp_cnt), 16);
    chk("ident_mis", int'(mismatch), 0);

    // Single corruption at pixel 5.
    setup(16, 16, 1, 100, 100, 0, 1);
    src_h[5] = 8'h2A;
    pulse_start();
    wait_end("corrupt");
    chk("corrupt_mis", int'(mismatch), 1);
    chk("corrupt_idx", int'(fail_idx), 5);
    chk("corrupt_ila", int'(fail_ila), 8'h05);
    chk("corrupt_hls", int'(fail_hls), 8'h2A);
    chk("corrupt_cnt", int'(cmp_cnt), 5);
    chk("corrupt_done", int'(done), 0);

    // Re-arm from FAIL.
    setup(16, 16, 1, 100, 100, 0, 1);
    pulse_start();
    chk("rearm_mis", int'(mismatch), 0);
    chk("rearm_fidx", int'(fail_idx), 0);
    chk("rearm_busy", int'(busy), 1);
    wait_end("rearm");
    chk("rearm_done", int'(done), 1);

    // Skewed arrival: ILA fills its FIFO before HLS begins with gaps.
    setup(16, 16, 1, 100, 100, 3, 0);
    pulse_start();
    chk("skew_tready_open", int'(ila_TREADY), 1);
    n = 0;
    while (idx_i < 16 && n < 200) begin
      tick();
      n++;
    end
    chk("skew_tready_full", int'(ila_TREADY), 0);
    chk("skew_occ", q_i.size(), 16);
    en_h = 1;
    wait_end("skew");
    chk("skew_done", int'(done), 1);
    chk("skew_stall", int'(stall_err), 0);

    // Starvation: one ILA word, no HLS.
    setup(1, 0, 0, 100, 100, 0, 1);
    pulse_start();
    n = 0;
    while (!stall_err && n < 300) begin
      tick();
      n++;
    end
    chk("starve_stall", int'(stall_err), 1);
    chk("starve_latency", cyc - first_push, 64);
    chk("starve_done", int'(done), 0);
    chk("starve_busy", int'(busy), 0);

    // Asynchronous reset after 7 compares, then a clean run.
    setup(16, 16, 1, 100, 100, 0, 1);
    pulse_start();
    n = 0;
    while (cmp_cnt < 7 && n < 100) begin
      tick();
      n++;
    end
    #1 rst = 1;
    #1;
    chk("arst_tready", int'({ila_TREADY, hls_TREADY}), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_flags", int'({done, mismatch, stall_err}), 0);
    chk("arst_fidx", int'(fail_idx), 0);
    chk("arst_fvals", int'({fail_ila, fail_hls}), 0);
    chk("arst_cnt", int'(cmp_cnt), 0);
    tick();
    rst = 0;
    tick();
    setup(16, 16, 1, 100, 100, 0, 1);
    pulse_start();
    wait_end("post_rst");
    chk("post_rst_done", int'(done), 1);
    chk("post_rst_cnt", int'(cmp_cnt), 16);

    // Randomized runs: throttling, late HLS, extra words, optional corruption.
    for (int r = 0; r < 12; r++) begin
      setup(16 + $urandom_range(0, 3), 16 + $urandom_range(0, 3), 0,
            $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 2), 0);
      if (r % 3 == 1) src_h[$urandom_range(0, 15)] ^= 8'($urandom_range(1, 255));
      pulse_start();
      repeat ($urandom_range(0, 20)) tick();
      en_h = 1;
      if (r == 5) pulse_start();
      wait_end("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
